// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO with optional
// first-word-fall-through output.
package sync_fifo_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int K_DEF      = 4;
   localparam int MODE_STD   = 0;
   localparam int MODE_FWFT  = 1;

   function automatic int depth_f(input int k);
      return 2 ** (k - 1);
   endfunction
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write port, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int K      = K_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [K-2:0]      waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [K-2:0]      raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int DEPTH = depth_f(K);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with wrap-bit pointers; FWFT selects between a registered
// read (data one cycle after rd_en) and a head-of-queue output register.
module sync_fifo_fwft
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int K      = K_DEF,
   parameter int FWFT   = MODE_STD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              valid,
   output logic [K-1:0]      count,
   output logic              overflow,
   output logic              underflow
);
   logic [K-1:0]      wr_ptr_q, wr_ptr_d;
   logic [K-1:0]      rd_ptr_q, rd_ptr_d;
   logic [K-1:0]      count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              ov_q, ov_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              mem_empty;
   logic              wr_accept;
   logic              rd_advance;
   logic              word_leaves;
   logic [DATA_W-1:0] mem_rdata;

   assign mem_empty = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[K-2:0] == rd_ptr_q[K-2:0]) &&
                      (wr_ptr_q[K-1] != rd_ptr_q[K-1]);
   assign wr_accept = wr_en && !full;

   fifo_mem #(
      .DATA_W (DATA_W),
      .K      (K)
   ) u_mem (
      .clk   (clk),
      .we    (wr_accept && rst_n),
      .waddr (wr_ptr_q[K-2:0]),
      .wdata (din),
      .raddr (rd_ptr_q[K-2:0]),
      .rdata (mem_rdata)
   );

   always_comb begin
      rd_advance  = 1'b0;
      word_leaves = 1'b0;
      dout_d      = dout_q;
      valid_d     = 1'b0;
      ov_d        = 1'b0;
      underflow_d = 1'b0;
      if (FWFT == MODE_FWFT) begin
         // Refill the output register whenever it is free or being popped.
         word_leaves = rd_en && ov_q;
         rd_advance  = !mem_empty && (!ov_q || word_leaves);
         underflow_d = rd_en && !ov_q;
         if (rd_advance) begin
            dout_d = mem_rdata;
            ov_d   = 1'b1;
         end else if (word_leaves) begin
            ov_d   = 1'b0;
         end else begin
            ov_d   = ov_q;
         end
      end else begin
         rd_advance  = rd_en && !mem_empty;
         word_leaves = rd_advance;
         underflow_d = rd_en && mem_empty;
         valid_d     = rd_advance;
         if (rd_advance) begin
            dout_d = mem_rdata;
         end
      end

      overflow_d = wr_en && full;
      wr_ptr_d   = wr_accept  ? wr_ptr_q + K'(1) : wr_ptr_q;
      rd_ptr_d   = rd_advance ? rd_ptr_q + K'(1) : rd_ptr_q;

      count_d = count_q;
      if (wr_accept && !word_leaves) begin
         count_d = count_q + K'(1);
      end else if (!wr_accept && word_leaves) begin
         count_d = count_q - K'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         dout_q      <= '0;
         valid_q     <= 1'b0;
         ov_q        <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         ov_q        <= ov_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign dout      = dout_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign empty     = (FWFT == MODE_FWFT) ? ~ov_q : mem_empty;
   assign valid     = (FWFT == MODE_FWFT) ? ov_q : valid_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench: one standard-mode and one FWFT-mode instance side by side.
module tb_sync_fifo_fwft;
   logic       clk = 1'b0;
   int         checks = 0;
   int         errors = 0;

   logic       s_rst_n = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
   logic [7:0] s_din = '0, s_dout;
   logic       s_full, s_empty, s_valid, s_overflow, s_underflow;
   logic [3:0] s_count;

   logic       f_rst_n = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
   logic [7:0] f_din = '0, f_dout;
   logic       f_full, f_empty, f_valid, f_overflow, f_underflow;
   logic [3:0] f_count;

   always #5 clk = ~clk;

   sync_fifo_fwft #(.DATA_W(8), .K(4), .FWFT(0)) u_std (
      .clk(clk), .rst_n(s_rst_n), .wr_en(s_wr_en), .din(s_din), .full(s_full),
      .rd_en(s_rd_en), .dout(s_dout), .empty(s_empty), .valid(s_valid),
      .count(s_count), .overflow(s_overflow), .underflow(s_underflow)
   );

   sync_fifo_fwft #(.DATA_W(8), .K(4), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(f_rst_n), .wr_en(f_wr_en), .din(f_din), .full(f_full),
      .rd_en(f_rd_en), .dout(f_dout), .empty(f_empty), .valid(f_valid),
      .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
   );

   // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      s_rst_n = 1'b0; f_rst_n = 1'b0;
      step(); step();
      s_rst_n = 1'b1; f_rst_n = 1'b1;
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL rst_s_empty: got %b exp 1", s_empty); end
      checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL rst_s_full: got %b exp 0", s_full); end
      checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL rst_s_count: got %0d exp 0", s_count); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_s_valid: got %b exp 0", s_valid); end
      checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL rst_s_dout: got %h exp 00", s_dout); end
      checks++; if ({s_overflow, s_underflow} !== 2'b00) begin errors++; $display("FAIL rst_s_pulses: got %b exp 00", {s_overflow, s_underflow}); end
      checks++; if ({f_empty, f_full, f_valid} !== 3'b100) begin errors++; $display("FAIL rst_f_flags: got %b exp 100", {f_empty, f_full, f_valid}); end
      checks++; if (f_count !== 4'd0) begin errors++; $display("FAIL rst_f_count: got %0d exp 0", f_count); end
      checks++; if (f_dout !== 8'h00) begin errors++; $display("FAIL rst_f_dout: got %h exp 00", f_dout); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 8; i++) begin
         s_wr_en = 1'b1; s_din = 8'(8'h10 + i);
         step();
         checks++; if (s_count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, s_count, i + 1); end
         checks++; if (s_full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d]: got %b exp %b", i, s_full, i == 7); end
      end
      s_din = 8'h18;
      step();
      s_wr_en = 1'b0;
      checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b exp 1", s_overflow); end
      checks++; if (s_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d exp 8", s_count); end
      step();
      checks++; if (s_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", s_overflow); end
      for (int i = 0; i < 8; i++) begin
         s_rd_en = 1'b1;
         step();
         checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b exp 1", i, s_valid); end
         checks++; if (s_dout !== 8'(8'h10 + i)) begin errors++; $display("FAIL drain_dout[%0d]: got %h exp %h", i, s_dout, 8'(8'h10 + i)); end
         checks++; if (s_count !== 4'(7 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d exp %0d", i, s_count, 7 - i); end
      end
      s_rd_en = 1'b0;
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b exp 1", s_empty); end
      step();
      checks++; if ({s_valid, s_dout} !== {1'b0, 8'h17}) begin errors++; $display("FAIL idle_hold: got %b/%h exp 0/17", s_valid, s_dout); end
      s_rd_en = 1'b1;
      step();
      s_rd_en = 1'b0;
      checks++; if ({s_underflow, s_valid} !== 2'b10) begin errors++; $display("FAIL udf_pulse: got %b exp 10", {s_underflow, s_valid}); end
      step();
      checks++; if (s_underflow !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b exp 0", s_underflow); end
   endtask

   task automatic test_wrap();
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < 3; j++) begin
            s_wr_en = 1'b1; s_din = 8'(8'h40 + r * 3 + j);
            step();
            checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL wrap_full[%0d.%0d]: got %b exp 0", r, j, s_full); end
         end
         s_wr_en = 1'b0;
         for (int j = 0; j < 3; j++) begin
            s_rd_en = 1'b1;
            step();
            checks++; if (s_dout !== 8'(8'h40 + r * 3 + j)) begin errors++; $display("FAIL wrap_dout[%0d.%0d]: got %h exp %h", r, j, s_dout, 8'(8'h40 + r * 3 + j)); end
         end
         s_rd_en = 1'b0;
      end
      checks++; if ({s_empty, s_count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL wrap_end: got %b/%0d exp 1/0", s_empty, s_count); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] tail [7];
      tail = '{8'h6B, 8'h6C, 8'h6D, 8'h70, 8'h71, 8'h72, 8'h73};
      for (int i = 0; i < 4; i++) begin
         s_wr_en = 1'b1; s_din = 8'(8'h60 + i);
         step();
      end
      for (int i = 0; i < 10; i++) begin
         s_wr_en = 1'b1; s_rd_en = 1'b1; s_din = 8'(8'h64 + i);
         step();
         checks++; if ({s_valid, s_dout} !== {1'b1, 8'(8'h60 + i)}) begin errors++; $display("FAIL rw_dout[%0d]: got %b/%h exp 1/%h", i, s_valid, s_dout, 8'(8'h60 + i)); end
         checks++; if (s_count !== 4'd4) begin errors++; $display("FAIL rw_count[%0d]: got %0d exp 4", i, s_count); end
      end
      s_rd_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_din = 8'(8'h70 + i);
         step();
      end
      checks++; if ({s_full, s_count} !== {1'b1, 4'd8}) begin errors++; $display("FAIL rw_full: got %b/%0d exp 1/8", s_full, s_count); end
      s_din = 8'hEE; s_rd_en = 1'b1;
      step();
      s_wr_en = 1'b0;
      checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL full_rw_ovf: got %b exp 1", s_overflow); end
      checks++; if ({s_valid, s_dout} !== {1'b1, 8'h6A}) begin errors++; $display("FAIL full_rw_read: got %b/%h exp 1/6a", s_valid, s_dout); end
      checks++; if (s_count !== 4'd7) begin errors++; $display("FAIL full_rw_count: got %0d exp 7", s_count); end
      for (int i = 0; i < 7; i++) begin
         step();
         checks++; if (s_dout !== tail[i]) begin errors++; $display("FAIL full_rw_drain[%0d]: got %h exp %h", i, s_dout, tail[i]); end
      end
      s_rd_en = 1'b0;
      checks++; if ({s_empty, s_count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL rw_end: got %b/%0d exp 1/0", s_empty, s_count); end
   endtask

   task automatic test_fwft_latency();
      logic [7:0] exp [9];
      exp = '{8'hA5, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
      f_wr_en = 1'b1; f_din = 8'hA5;
      step();
      f_wr_en = 1'b0;
      checks++; if ({f_empty, f_count} !== {1'b1, 4'd1}) begin errors++; $display("FAIL fwft_edge_n: got %b/%0d exp 1/1", f_empty, f_count); end
      step();
      checks++; if ({f_empty, f_valid, f_dout} !== {2'b01, 8'hA5}) begin errors++; $display("FAIL fwft_edge_n1: got %b%b/%h exp 01/a5", f_empty, f_valid, f_dout); end
      for (int i = 0; i < 9; i++) begin
         f_wr_en = 1'b1; f_din = 8'(8'hB0 + i);
         step();
         checks++; if (f_count !== 4'((i < 8) ? i + 2 : 9)) begin errors++; $display("FAIL fwft_fill_count[%0d]: got %0d exp %0d", i, f_count, (i < 8) ? i + 2 : 9); end
      end
      f_wr_en = 1'b0;
      checks++; if ({f_full, f_overflow} !== 2'b11) begin errors++; $display("FAIL fwft_full_ovf: got %b exp 11", {f_full, f_overflow}); end
      f_rd_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         checks++; if ({f_valid, f_dout} !== {1'b1, exp[i]}) begin errors++; $display("FAIL fwft_pop[%0d]: got %b/%h exp 1/%h", i, f_valid, f_dout, exp[i]); end
         step();
      end
      checks++; if ({f_empty, f_count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL fwft_drained: got %b/%0d exp 1/0", f_empty, f_count); end
      step();
      f_rd_en = 1'b0;
      checks++; if (f_underflow !== 1'b1) begin errors++; $display("FAIL fwft_udf: got %b exp 1", f_underflow); end
      step();
      checks++; if (f_underflow !== 1'b0) begin errors++; $display("FAIL fwft_udf_clear: got %b exp 0", f_underflow); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         s_wr_en = 1'b1; s_din = 8'(8'h80 + i);
         f_wr_en = 1'b1; f_din = 8'(8'hE0 + i);
         step();
      end
      s_wr_en = 1'b0; f_wr_en = 1'b0; s_rd_en = 1'b1;
      step();
      checks++; if (s_dout !== 8'h80) begin errors++; $display("FAIL mid_read: got %h exp 80", s_dout); end
      s_rst_n = 1'b0; f_rst_n = 1'b0;
      s_wr_en = 1'b1; s_din = 8'h99; f_rd_en = 1'b1;
      step();
      s_rst_n = 1'b1; f_rst_n = 1'b1;
      s_wr_en = 1'b0; s_rd_en = 1'b0; f_rd_en = 1'b0;
      checks++; if ({s_empty, s_valid, s_count, s_dout} !== {2'b10, 4'd0, 8'h00}) begin errors++; $display("FAIL mid_rst_s: got %b%b/%0d/%h exp 10/0/00", s_empty, s_valid, s_count, s_dout); end
      checks++; if ({f_empty, f_valid, f_count} !== {2'b10, 4'd0}) begin errors++; $display("FAIL mid_rst_f: got %b%b/%0d exp 10/0", f_empty, f_valid, f_count); end
      step();
      checks++; if ({s_overflow, s_underflow, f_underflow, s_empty} !== 4'b0001) begin errors++; $display("FAIL mid_no_pulse: got %b exp 0001", {s_overflow, s_underflow, f_underflow, s_empty}); end
      s_wr_en = 1'b1; s_din = 8'hC0; f_wr_en = 1'b1; f_din = 8'hD0;
      step();
      s_wr_en = 1'b0; f_wr_en = 1'b0; s_rd_en = 1'b1;
      step();
      checks++; if ({s_valid, s_dout} !== {1'b1, 8'hC0}) begin errors++; $display("FAIL post_rst_s: got %b/%h exp 1/c0", s_valid, s_dout); end
      checks++; if ({f_valid, f_dout, f_count} !== {1'b1, 8'hD0, 4'd1}) begin errors++; $display("FAIL post_rst_f: got %b/%h/%0d exp 1/d0/1", f_valid, f_dout, f_count); end
      f_rd_en = 1'b1;
      step();
      s_rd_en = 1'b0; f_rd_en = 1'b0;
      checks++; if ({s_underflow, s_valid} !== 2'b10) begin errors++; $display("FAIL post_rst_s_empty: got %b exp 10", {s_underflow, s_valid}); end
      checks++; if ({f_empty, f_count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL post_rst_f_empty: got %b/%0d exp 1/0", f_empty, f_count); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
      test_fwft_latency();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
